syn_pad_bank: RTL and testbench

- Parametrised, multi-channel successor to the single-pad synthesis cell.
- Groups NUM_CH pads under one mode: INPUT, OUTPUT or bidirectional INOUT.
- Input path: metastability synchroniser, glitch filter and edge detection. Output path: optional registered data and output enable.
- Sits between fabric logic and the VPR pad primitives; one instance replaces NUM_CH single-pad cells.

---
 rtl/syn_pad_bank.sv | 172 +++++++++++++++++
 tb/tb_syn_pad_bank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/syn_pad_bank.sv
// syn_pad_bank: a bank of NUM_CH pads under one mode (INPUT, OUTPUT, INOUT).
// Input path: synchroniser chain, per-channel glitch filter, edge pulses.
// Output path: optional registered data/enable towards the pad driver.
module syn_pad_bank #(
  parameter int    NUM_CH      = 4,
  parameter string MODE        = "INPUT",
  parameter int    SYNC_STAGES = 2,
  parameter int    FILTER_LEN  = 3,
  parameter int    REG_OUT     = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NUM_CH-1:0] I,
  input  logic [NUM_CH-1:0] OE,
  output logic [NUM_CH-1:0] O,
  output logic [NUM_CH-1:0] RISE,
  output logic [NUM_CH-1:0] FALL,
  input  logic [NUM_CH-1:0] PAD_IN,
  output logic [NUM_CH-1:0] PAD_OUT,
  output logic [NUM_CH-1:0] PAD_OE
);

  localparam bit MODE_IN  = (MODE == "INPUT");
  localparam bit MODE_OUT = (MODE == "OUTPUT");
  localparam bit MODE_IO  = (MODE == "INOUT");

  if (!(MODE_IN || MODE_OUT || MODE_IO)) begin : g_bad_mode
    $error("syn_pad_bank: MODE must be INPUT, OUTPUT or INOUT");
  end
  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("syn_pad_bank: NUM_CH must be 1..32");
  end
  if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("syn_pad_bank: SYNC_STAGES must be 1..4");
  end
  if (FILTER_LEN < 0 || FILTER_LEN > 15) begin : g_bad_filter
    $error("syn_pad_bank: FILTER_LEN must be 0..15");
  end

  // ---------------------------------------------------------------- input path
  if (!MODE_OUT) begin : g_in
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] s_s;
    logic [NUM_CH-1:0] o_d;
    logic [NUM_CH-1:0] o_q;
    logic [NUM_CH-1:0] o_prev_q;
    logic [NUM_CH-1:0] rise_q;
    logic [NUM_CH-1:0] fall_q;

    // Metastability chain: PAD_IN enters stage 0, the last stage feeds the filter.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= {NUM_CH{1'b0}};
      end else begin
        sync_q[0] <= PAD_IN;
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign s_s = sync_q[SYNC_STAGES-1];

    if (FILTER_LEN > 0) begin : g_filt
      localparam int CNT_W = $clog2(FILTER_LEN + 1);
      logic [CNT_W-1:0] cnt_q [NUM_CH];
      logic [CNT_W-1:0] cnt_d [NUM_CH];

      // Count consecutive cycles where S differs from O; adopt S once the count completes.
      always_comb begin
        o_d = o_q;
        for (int k = 0; k < NUM_CH; k++) begin
          cnt_d[k] = {CNT_W{1'b0}};
          if (s_s[k] == o_q[k]) begin
            cnt_d[k] = {CNT_W{1'b0}};
          end else if (cnt_q[k] == CNT_W'(FILTER_LEN - 1)) begin
            o_d[k]   = s_s[k];
            cnt_d[k] = {CNT_W{1'b0}};
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end
      end

      // Filter counters, one per channel.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= {CNT_W{1'b0}};
        end else begin
          for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_d[k];
        end
      end
    end else begin : g_nofilt
      // Filter bypassed: O follows the synchronised input directly.
      always_comb begin
        o_d = s_s;
      end
    end

    // Filtered level plus registered edge compare against the previous level.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        o_q      <= {NUM_CH{1'b0}};
        o_prev_q <= {NUM_CH{1'b0}};
        rise_q   <= {NUM_CH{1'b0}};
        fall_q   <= {NUM_CH{1'b0}};
      end else begin
        o_q      <= o_d;
        o_prev_q <= o_q;
        rise_q   <= o_q & ~o_prev_q;
        fall_q   <= ~o_q & o_prev_q;
      end
    end

    assign O    = o_q;
    assign RISE = rise_q;
    assign FALL = fall_q;
  end else begin : g_no_in
    logic unused_pad_in_s;
    assign unused_pad_in_s = ^PAD_IN;
    assign O    = {NUM_CH{1'b0}};
    assign RISE = {NUM_CH{1'b0}};
    assign FALL = {NUM_CH{1'b0}};
  end

  // --------------------------------------------------------------- output path
  if (MODE_IN) begin : g_no_out
    logic unused_fabric_s;
    assign unused_fabric_s = ^{I, OE};
    assign PAD_OUT = {NUM_CH{1'b0}};
    assign PAD_OE  = {NUM_CH{1'b0}};
  end else begin : g_out
    logic [NUM_CH-1:0] en_s;

    if (MODE_OUT) begin : g_en_all
      logic unused_oe_s;
      assign unused_oe_s = ^OE;
      assign en_s = {NUM_CH{1'b1}};
    end else begin : g_en_oe
      assign en_s = OE;
    end

    if (REG_OUT != 0) begin : g_reg
      logic [NUM_CH-1:0] pad_out_q;
      logic [NUM_CH-1:0] pad_oe_q;

      // Register fabric data and enable towards the pad driver.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          pad_out_q <= {NUM_CH{1'b0}};
          pad_oe_q  <= {NUM_CH{1'b0}};
        end else begin
          pad_out_q <= I;
          pad_oe_q  <= en_s;
        end
      end

      assign PAD_OUT = pad_out_q;
      assign PAD_OE  = pad_oe_q;
    end else begin : g_comb
      // Pass-through to the pad, forced quiet while reset is asserted.
      always_comb begin
        if (RST_N) begin
          PAD_OUT = I;
          PAD_OE  = en_s;
        end else begin
          PAD_OUT = {NUM_CH{1'b0}};
          PAD_OE  = {NUM_CH{1'b0}};
        end
      end
    end
  end

endmodule

// File: tb/tb_syn_pad_bank.sv
// Bench for syn_pad_bank: INPUT (defaults), OUTPUT registered, OUTPUT
// combinational and INOUT instances, checked against a history-based model.
module tb_syn_pad_bank;
  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int FL   = 3;
  localparam int H    = SYNC + FL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  // INPUT instance (a)
  logic [N-1:0] i_a = '0, oe_a = '0, pin_a = '0;
  logic [N-1:0] o_a, rise_a, fall_a, pout_a, poe_a;
  // OUTPUT registered (b)
  logic [N-1:0] i_b = '0, oe_b = '0, pin_b = '0;
  logic [N-1:0] o_b, rise_b, fall_b, pout_b, poe_b;
  // OUTPUT combinational (c)
  logic [N-1:0] i_c = '0, oe_c = '0, pin_c = '0;
  logic [N-1:0] o_c, rise_c, fall_c, pout_c, poe_c;
  // INOUT (d) with loopback on driven channels
  logic [N-1:0] i_d = '0, oe_d = '0, ext_d = '0;
  logic [N-1:0] pin_d, o_d, rise_d, fall_d, pout_d, poe_d;
  assign pin_d = (pout_d & poe_d) | (ext_d & ~poe_d);

  syn_pad_bank u_a (.CLK(clk), .RST_N(rst_n), .I(i_a), .OE(oe_a), .O(o_a), .RISE(rise_a),
                    .FALL(fall_a), .PAD_IN(pin_a), .PAD_OUT(pout_a), .PAD_OE(poe_a));
  syn_pad_bank #(.MODE("OUTPUT"), .REG_OUT(1)) u_b (.CLK(clk), .RST_N(rst_n), .I(i_b), .OE(oe_b),
                    .O(o_b), .RISE(rise_b), .FALL(fall_b), .PAD_IN(pin_b), .PAD_OUT(pout_b), .PAD_OE(poe_b));
  syn_pad_bank #(.MODE("OUTPUT"), .REG_OUT(0)) u_c (.CLK(clk), .RST_N(rst_n), .I(i_c), .OE(oe_c),
                    .O(o_c), .RISE(rise_c), .FALL(fall_c), .PAD_IN(pin_c), .PAD_OUT(pout_c), .PAD_OE(poe_c));
  syn_pad_bank #(.MODE("INOUT"), .REG_OUT(1)) u_d (.CLK(clk), .RST_N(rst_n), .I(i_d), .OE(oe_d),
                    .O(o_d), .RISE(rise_d), .FALL(fall_d), .PAD_IN(pin_d), .PAD_OUT(pout_d), .PAD_OE(poe_d));

  always #5 clk = ~clk;

  // Reference model: hist[j] = PAD_IN of instance a sampled j edges ago.
  logic [N-1:0] hist [H];
  logic [N-1:0] m_o, m_o1, m_rise, m_fall, m_b_out, m_b_oe, m_d_out, m_d_oe;

  task automatic model_reset();
    for (int j = 0; j < H; j++) hist[j] = '0;
    m_o = '0; m_o1 = '0; m_rise = '0; m_fall = '0;
    m_b_out = '0; m_b_oe = '0; m_d_out = '0; m_d_oe = '0;
  endtask

  // A channel flips O once the last FL synchronised samples all disagree with it.
  task automatic model_edge();
    logic [N-1:0] nxt;
    bit all_diff;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int j = H - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = pin_a;
      nxt = m_o;
      for (int k = 0; k < N; k++) begin
        all_diff = 1'b1;
        for (int i = 0; i < FL; i++) if (hist[SYNC+i][k] == m_o[k]) all_diff = 1'b0;
        if (all_diff) nxt[k] = ~m_o[k];
      end
      m_rise = m_o & ~m_o1;
      m_fall = ~m_o & m_o1;
      m_o1 = m_o;
      m_o = nxt;
      m_b_out = i_b; m_b_oe = 4'hF;
      m_d_out = i_d; m_d_oe = oe_d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      pin_a = 4'($urandom); i_b = 4'($urandom); i_c = 4'($urandom);
      i_d = 4'($urandom); oe_d = 4'($urandom); ext_d = 4'($urandom);
      tick();
      checks++;
      if ({o_a, rise_a, fall_a, pout_a, poe_a, pout_b, poe_b, pout_c, poe_c, o_d, pout_d, poe_d} !== '0) begin
        errors++;
        $display("FAIL reset_hold: a=%b/%b/%b/%b/%b b=%b/%b c=%b/%b d=%b/%b/%b expected all 0",
                 o_a, rise_a, fall_a, pout_a, poe_a, pout_b, poe_b, pout_c, poe_c, o_d, pout_d, poe_d);
      end
    end
    pin_a = '0; i_b = '0; i_c = '0; i_d = '0; oe_d = '0; ext_d = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({rise_a, fall_a, o_a} !== '0) begin
        errors++;
        $display("FAIL reset_release: O=%b RISE=%b FALL=%b expected 0", o_a, rise_a, fall_a);
      end
      checks++;
      if (poe_b !== 4'hF) begin
        errors++;
        $display("FAIL out_oe_after_reset: PAD_OE=%b expected 1111", poe_b);
      end
    end
  endtask

  task automatic test_latency();
    int cnt = 0;
    pin_a = 4'b0001;
    while (o_a[0] !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    checks++;
    if (cnt != SYNC + FL) begin errors++; $display("FAIL latency: edges=%0d expected %0d", cnt, SYNC + FL); end
    checks++;
    if (rise_a !== 4'b0000 || o_a !== 4'b0001) begin
      errors++; $display("FAIL latency_o: O=%b RISE=%b expected 0001/0000", o_a, rise_a);
    end
    tick();
    checks++;
    if (rise_a !== 4'b0001 || fall_a !== 4'b0000) begin
      errors++; $display("FAIL rise_pulse: RISE=%b FALL=%b expected 0001/0000", rise_a, fall_a);
    end
    tick();
    checks++;
    if (rise_a !== 4'b0000 || o_a !== 4'b0001) begin
      errors++; $display("FAIL rise_single: RISE=%b O=%b expected 0000/0001", rise_a, o_a);
    end
  endtask

  task automatic test_glitch();
    bit seen = 1'b0;
    pin_a[1] = 1'b1; tick(); tick(); pin_a[1] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (o_a[1] !== 1'b0 || rise_a[1] !== 1'b0) begin
        errors++; $display("FAIL glitch_reject: O=%b RISE=%b expected ch1 0", o_a, rise_a);
      end
    end
    pin_a[1] = 1'b1; tick(); tick(); tick(); pin_a[1] = 1'b0;
    for (int c = 0; c < 10; c++) begin tick(); if (o_a[1] === 1'b1) seen = 1'b1; end
    checks++;
    if (!seen) begin errors++; $display("FAIL glitch_accept: O[1] never rose, expected 1"); end
    checks++;
    if (o_a !== m_o) begin errors++; $display("FAIL glitch_model: O=%b expected %b", o_a, m_o); end
  endtask

  task automatic test_mid_reset();
    int cnt = 0;
    pin_a = 4'b0101;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({o_a, rise_a, fall_a, pout_b, poe_b, pout_c} !== '0) begin
      errors++; $display("FAIL async_reset: O=%b RISE=%b FALL=%b PAD_OUT_b=%b PAD_OE_b=%b PAD_OUT_c=%b expected 0",
                         o_a, rise_a, fall_a, pout_b, poe_b, pout_c);
    end
    #2;
    rst_n = 1'b1;
    while (o_a[2] !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    checks++;
    if (cnt != SYNC + FL || o_a !== 4'b0101) begin
      errors++; $display("FAIL reset_refilter: edges=%0d O=%b expected %0d/0101", cnt, o_a, SYNC + FL);
    end
  endtask

  task automatic test_output();
    i_b = 4'b1010; i_c = 4'b1010;
    #1;
    checks++;
    if (pout_c !== 4'b1010 || poe_c !== 4'b1111) begin
      errors++; $display("FAIL out_comb: PAD_OUT=%b PAD_OE=%b expected 1010/1111", pout_c, poe_c);
    end
    checks++;
    if (pout_b !== m_b_out) begin errors++; $display("FAIL out_reg_hold: PAD_OUT=%b expected %b", pout_b, m_b_out); end
    tick();
    checks++;
    if (pout_b !== 4'b1010 || poe_b !== 4'b1111 || {o_b, rise_b, fall_b, o_c} !== '0) begin
      errors++; $display("FAIL out_reg: PAD_OUT=%b PAD_OE=%b O=%b expected 1010/1111/0000", pout_b, poe_b, o_b);
    end
    i_c = 4'b0101;
    #1;
    checks++;
    if (pout_c !== 4'b0101) begin errors++; $display("FAIL out_comb2: PAD_OUT=%b expected 0101", pout_c); end
  endtask

  task automatic test_inout();
    oe_d = 4'b0011; i_d = 4'b0001; ext_d = 4'b1000;
    repeat (10) tick();
    checks++;
    if (poe_d !== 4'b0011 || pout_d !== 4'b0001) begin
      errors++; $display("FAIL inout_drive: PAD_OE=%b PAD_OUT=%b expected 0011/0001", poe_d, pout_d);
    end
    checks++;
    if (o_d !== 4'b1001) begin errors++; $display("FAIL inout_loop: O=%b expected 1001", o_d); end
    ext_d = 4'b0100;
    repeat (10) tick();
    checks++;
    if (o_d !== 4'b0101) begin errors++; $display("FAIL inout_ext: O=%b expected 0101", o_d); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 400; c++) begin
      pin_a = pin_a ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      i_b = 4'($urandom); i_c = 4'($urandom);
      i_d = 4'($urandom); oe_d = 4'($urandom); ext_d = 4'($urandom);
      tick();
      checks++;
      if (o_a !== m_o || rise_a !== m_rise || fall_a !== m_fall || (rise_a & fall_a) !== '0) begin
        errors++;
        if (bad++ < 10) $display("FAIL rand_in: O=%b RISE=%b FALL=%b expected %b/%b/%b",
                                 o_a, rise_a, fall_a, m_o, m_rise, m_fall);
      end
      checks++;
      if (pout_b !== m_b_out || poe_b !== m_b_oe || pout_c !== i_c || pout_d !== m_d_out || poe_d !== m_d_oe) begin
        errors++;
        if (bad++ < 10) $display("FAIL rand_out: b=%b/%b c=%b d=%b/%b expected %b/%b %b %b/%b",
                                 pout_b, poe_b, pout_c, pout_d, poe_d, m_b_out, m_b_oe, i_c, m_d_out, m_d_oe);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_glitch();
    test_mid_reset();
    test_output();
    test_inout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
